// File: rtl/fsm_state_monitor_pkg.sv
// Shared definitions for the sequencer and its receive-side monitor:
// sequencer state codes, per-state LED codes and monitor state encodings.
package fsm_state_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3
  } seq_state_e;

  localparam logic [7:0] LED_IDLE  = 8'd0;
  localparam logic [7:0] LED_COUNT = 8'd10;
  localparam logic [7:0] LED_WAIT  = 8'd5;
  localparam logic [7:0] LED_DONE  = 8'd15;

  typedef enum logic [1:0] {
    M_SYNC  = 2'd0,
    M_TRACK = 2'd1,
    M_FAULT = 2'd2
  } mon_state_e;

  // Bit positions inside err_flags
  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_UNKNOWN = 1;
  localparam int ERR_LED     = 2;
  localparam int ERR_DWELL   = 3;

  function automatic logic [7:0] expected_led(input logic [1:0] code);
    logic [7:0] led;
    case (code)
      2'd0:    led = LED_IDLE;
      2'd1:    led = LED_COUNT;
      2'd2:    led = LED_WAIT;
      default: led = LED_DONE;
    endcase
    return led;
  endfunction

  // Successor in the IDLE->COUNT->WAIT->DONE->IDLE ring
  function automatic logic [2:0] next_code(input logic [2:0] code);
    logic [1:0] lo;
    lo = code[1:0] + 2'd1;
    return {1'b0, lo};
  endfunction

endpackage

// File: rtl/fsm_state_monitor_if.sv
// Pin-side bundle between the sequencer status outputs (plus board controls)
// and the state monitor.
interface fsm_state_monitor_if #(
  parameter int DWELL_W = 8,
  parameter int SEQ_W   = 8
);
  logic               sample_en;
  logic [2:0]         state_in;
  logic [7:0]         led_in;
  logic               clr_err;
  logic [1:0]         mon_state;
  logic [SEQ_W-1:0]   seq_count;
  logic [DWELL_W-1:0] dwell_last;
  logic [3:0]         err_flags;
  logic               err_any;

  modport master (
    output sample_en, state_in, led_in, clr_err,
    input  mon_state, seq_count, dwell_last, err_flags, err_any
  );

  modport slave (
    input  sample_en, state_in, led_in, clr_err,
    output mon_state, seq_count, dwell_last, err_flags, err_any
  );
endinterface

// File: rtl/fsm_dwell_counter.sv
// Saturating dwell counter: load-1 has priority over increment; otherwise holds.
module fsm_dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_one,
  input  logic               incr,
  output logic [DWELL_W-1:0] count
);

  localparam logic [DWELL_W-1:0] CNT_MAX = '1;
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load_one) begin
      count <= CNT_ONE;
    end else if (incr && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/fsm_state_monitor.sv
// Receive-side checker for the sequencer status pins: verifies the state ring,
// per-state LED code and COUNT dwell, and reports sequences and sticky errors.
module fsm_state_monitor
  import fsm_state_monitor_pkg::*;
#(
  parameter int DWELL_W         = 8,
  parameter int SEQ_W           = 8,
  parameter int EXP_COUNT_DWELL = 4
) (
  input  logic                clk,
  input  logic                reset,
  fsm_state_monitor_if.slave  bus
);

  localparam logic [DWELL_W-1:0] EXP_DWELL = DWELL_W'(EXP_COUNT_DWELL);

  logic               vld_p0;
  logic               clr_p0;
  logic [2:0]         state_p0;
  logic [7:0]         led_p0;

  mon_state_e         mon_q, mon_d;
  logic [2:0]         prev_q, prev_d;
  logic [SEQ_W-1:0]   seq_q;
  logic [DWELL_W-1:0] dwell_last_q;
  logic [3:0]         flags_q, flags_d;
  logic               err_any_q;

  logic [DWELL_W-1:0] dwell;
  logic               dwell_load, dwell_inc;
  logic               cap_last, seq_inc;
  logic [3:0]         new_err;
  logic               unknown, same, legal;

  // Stage p0: capture the pins; all checking works on this registered copy
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      clr_p0 <= 1'b0;
    end else begin
      vld_p0 <= bus.sample_en;
      clr_p0 <= bus.clr_err;
    end
  end

  always_ff @(posedge clk) begin
    state_p0 <= bus.state_in;
    led_p0   <= bus.led_in;
  end

  assign unknown = state_p0[2];
  assign same    = (state_p0 == prev_q);
  assign legal   = (state_p0 == next_code(prev_q));

  fsm_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load_one (dwell_load),
    .incr     (dwell_inc),
    .count    (dwell)
  );

  // Stage p1: transition checker, LED checker and monitor FSM
  always_comb begin
    mon_d      = mon_q;
    prev_d     = prev_q;
    dwell_load = 1'b0;
    dwell_inc  = 1'b0;
    cap_last   = 1'b0;
    seq_inc    = 1'b0;
    new_err    = '0;

    if (vld_p0) begin
      if (mon_q == M_SYNC) begin
        if (state_p0 == S_IDLE) begin
          prev_d     = S_IDLE;
          dwell_load = 1'b1;
          mon_d      = M_TRACK;
        end
      end else if (unknown) begin
        // Unknown codes carry no usable state, so tracking holds
        new_err[ERR_UNKNOWN] = 1'b1;
      end else begin
        if (led_p0 != expected_led(state_p0[1:0])) begin
          new_err[ERR_LED] = 1'b1;
        end
        if (same) begin
          dwell_inc = 1'b1;
        end else begin
          cap_last   = 1'b1;
          dwell_load = 1'b1;
          prev_d     = state_p0;
          if (legal) begin
            if ((prev_q == S_COUNT) && (dwell != EXP_DWELL)) begin
              new_err[ERR_DWELL] = 1'b1;
            end
            if ((prev_q == S_DONE) && (mon_q == M_TRACK)) begin
              seq_inc = 1'b1;
            end
          end else begin
            new_err[ERR_ILLEGAL] = 1'b1;
          end
        end
      end
    end

    // A fresh error outranks a simultaneous clear
    flags_d = (clr_p0 ? 4'b0000 : flags_q) | new_err;
    if (new_err != 4'b0000) begin
      mon_d = M_FAULT;
    end else if (clr_p0) begin
      mon_d = M_SYNC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mon_q        <= M_SYNC;
      prev_q       <= S_IDLE;
      seq_q        <= '0;
      dwell_last_q <= '0;
      flags_q      <= '0;
      err_any_q    <= 1'b0;
    end else begin
      mon_q     <= mon_d;
      prev_q    <= prev_d;
      flags_q   <= flags_d;
      err_any_q <= |flags_d;
      if (seq_inc) begin
        seq_q <= seq_q + SEQ_W'(1);
      end
      if (cap_last) begin
        dwell_last_q <= dwell;
      end
    end
  end

  assign bus.mon_state  = mon_q;
  assign bus.seq_count  = seq_q;
  assign bus.dwell_last = dwell_last_q;
  assign bus.err_flags  = flags_q;
  assign bus.err_any    = err_any_q;

endmodule
